// File: rtl/motor_duty_ramp.sv
// motor_duty_ramp: slew-rate limiter driving the pwm_generator width input.
// Commands arrive over a valid/ready handshake; width moves toward the
// commanded duty by at most RAMP_STEP once per update tick.
//
// Build option: MOTOR_RAMP_REVERSE_GUARD_EN
//   defined   - a reversal decelerates to zero, dwells one tick, then flips dir
//   undefined - a reversal snaps width to 0 and flips dir on the accept edge,
//               cmd_ready is constant 1
//
// state | meaning
// IDLE  | width/dir equal the accepted target
// RAMP  | same direction, stepping toward target on each tick
// DECEL | reversal pending, stepping toward zero (guard build only)
// DWELL | width held at zero until next tick, then dir flips (guard build only)
module motor_duty_ramp #(
    parameter int BAND_WIDTH       = 32,
    parameter int PWM_PERIOD_CYCLE = 1000,
    parameter int RAMP_STEP        = 10,
    parameter int UPDATE_CYCLE     = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [BAND_WIDTH-1:0] cmd_duty,
    input  logic                  cmd_dir,
    output logic [BAND_WIDTH-1:0] width,
    output logic                  dir,
    output logic                  busy
);

    localparam int CNT_W = (UPDATE_CYCLE > 1) ? $clog2(UPDATE_CYCLE) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(UPDATE_CYCLE - 1);
    localparam logic [BAND_WIDTH-1:0] DUTY_MAX = BAND_WIDTH'(PWM_PERIOD_CYCLE + 1);
    localparam logic [BAND_WIDTH-1:0] STEP     = BAND_WIDTH'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, RAMP, DECEL, DWELL} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        tick_cnt;
    logic [BAND_WIDTH-1:0]   target;
    logic [BAND_WIDTH-1:0]   duty_clamped;
    logic [BAND_WIDTH-1:0]   width_adv;
    logic                    tick;
    logic                    accept;
`ifdef MOTOR_RAMP_REVERSE_GUARD_EN
    logic                    target_dir;
    logic                    ready_q;
`endif

    // Move cur toward goal by at most STEP; differences are taken so the
    // result never passes goal and never wraps.
    function automatic logic [BAND_WIDTH-1:0] step_to(
        input logic [BAND_WIDTH-1:0] cur,
        input logic [BAND_WIDTH-1:0] goal
    );
        logic [BAND_WIDTH-1:0] diff;
        if (goal > cur) begin
            diff    = goal - cur;
            step_to = cur + ((diff > STEP) ? STEP : diff);
        end else begin
            diff    = cur - goal;
            step_to = cur - ((diff > STEP) ? STEP : diff);
        end
    endfunction

`ifdef MOTOR_RAMP_REVERSE_GUARD_EN
    assign cmd_ready = ready_q;
`else
    assign cmd_ready = 1'b1;
`endif

    assign tick         = (tick_cnt == CNT_LAST);
    assign accept       = cmd_valid && cmd_ready;
    assign duty_clamped = (cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd_duty;

    // Width this edge would produce from the old target; a command accepted on
    // a tick edge only takes effect from the following tick.
    always_comb begin
        width_adv = width;
        if (tick) begin
            if (state == RAMP)
                width_adv = step_to(width, target);
            else if (state == DECEL)
                width_adv = step_to(width, '0);
        end
    end

    // Tick counter, command capture and ramp FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            target   <= '0;
            width    <= '0;
            dir      <= 1'b0;
            busy     <= 1'b0;
`ifdef MOTOR_RAMP_REVERSE_GUARD_EN
            target_dir <= 1'b0;
            ready_q    <= 1'b1;
`endif
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);

            case (state)
                IDLE, RAMP: begin
                    width <= width_adv;
                    if (state == RAMP && tick && width_adv == target) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    if (accept) begin
                        target <= duty_clamped;
                        if (cmd_dir != dir) begin
`ifdef MOTOR_RAMP_REVERSE_GUARD_EN
                            target_dir <= cmd_dir;
                            ready_q    <= 1'b0;
                            busy       <= 1'b1;
                            state      <= (width_adv == '0) ? DWELL : DECEL;
`else
                            width <= '0;
                            dir   <= cmd_dir;
                            if (duty_clamped == '0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= RAMP;
                                busy  <= 1'b1;
                            end
`endif
                        end else if (width_adv == duty_clamped) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end
                end
`ifdef MOTOR_RAMP_REVERSE_GUARD_EN
                DECEL: begin
                    width <= width_adv;
                    if (tick && width_adv == '0)
                        state <= DWELL;
                end
                DWELL: begin
                    if (tick) begin
                        dir     <= target_dir;
                        ready_q <= 1'b1;
                        if (target == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_duty_ramp.sv
// Directed bench for motor_duty_ramp with a short update period.
// Expected widths are queued when a command is driven and compared per tick.
module tb_motor_duty_ramp;

    localparam int BW     = 32;
    localparam int PERIOD = 1000;
    localparam int STEP   = 10;
    localparam int UPD    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [BW-1:0] cmd_duty = '0;
    logic          cmd_ready;
    logic [BW-1:0] width;
    logic          dir;
    logic          busy;

    int            errors = 0;
    int            checks = 0;
    int            m_cnt;
    logic [BW-1:0] exp_q[$];

    motor_duty_ramp #(
        .BAND_WIDTH      (BW),
        .PWM_PERIOD_CYCLE(PERIOD),
        .RAMP_STEP       (STEP),
        .UPDATE_CYCLE    (UPD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_duty (cmd_duty),
        .cmd_dir  (cmd_dir),
        .width    (width),
        .dir      (dir),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Independent tick phase: value 0 after an edge means that edge was a tick.
    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt <= 0;
        else     m_cnt <= (m_cnt == UPD - 1) ? 0 : m_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_tick();
        do @(negedge clk); while (m_cnt != 0);
    endtask

    task automatic wait_phase(input int p);
        do @(negedge clk); while (m_cnt != p);
    endtask

    task automatic send(input logic [BW-1:0] d, input logic dr);
        check("ready_before_send", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b1;
        cmd_duty  = d;
        cmd_dir   = dr;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_queue(input string tag);
        while (exp_q.size() != 0) begin
            next_tick();
            check(tag, width, exp_q.pop_front());
        end
    endtask

    initial begin
        int bad;
        int v;

        // reset state and quiet idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_width", width, 0);
        check("rst_dir", {31'd0, dir}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ready", {31'd0, cmd_ready}, 1);
        rst = 1'b0;
        bad = 0;
        repeat (3000) begin
            @(negedge clk);
            if (width != 0 || dir != 1'b0 || busy != 1'b0 || cmd_ready != 1'b1) bad++;
        end
        check("idle_stable_bad_cycles", bad, 0);

        // basic ramp 0 -> 35
        next_tick();
        send(35, 1'b0);
        check("accept_busy_rise", {31'd0, busy}, 1);
        check("accept_width_held", width, 0);
        exp_q.push_back(10); exp_q.push_back(20);
        exp_q.push_back(30); exp_q.push_back(35);
        run_queue("ramp35");
        check("ramp35_busy_fall", {31'd0, busy}, 0);

        // retarget downward mid-ramp
        send(100, 1'b0);
        exp_q.push_back(45); exp_q.push_back(55);
        run_queue("ramp100");
        check("ramp100_busy", {31'd0, busy}, 1);
        send(40, 1'b0);
        exp_q.push_back(45); exp_q.push_back(40);
        run_queue("retarget40");
        check("retarget40_busy", {31'd0, busy}, 0);

        // accept coinciding with a tick steps with the old target
        send(80, 1'b0);
        exp_q.push_back(50);
        run_queue("ramp80");
        wait_phase(UPD - 1);
        send(45, 1'b0);
        check("tick_accept_old_target", width, 60);
        check("tick_accept_busy", {31'd0, busy}, 1);
        exp_q.push_back(50); exp_q.push_back(45);
        run_queue("tick_accept_new_target");
        check("tick_accept_done_busy", {31'd0, busy}, 0);

        // settle at 30, then reverse
        send(30, 1'b0);
        exp_q.push_back(35); exp_q.push_back(30);
        run_queue("down30");
`ifdef MOTOR_RAMP_REVERSE_GUARD_EN
        send(20, 1'b1);
        check("decel_ready", {31'd0, cmd_ready}, 0);
        check("decel_busy", {31'd0, busy}, 1);
        check("decel_dir_held", {31'd0, dir}, 0);
        exp_q.push_back(20); exp_q.push_back(10); exp_q.push_back(0);
        run_queue("decel");
        check("dwell_dir_held", {31'd0, dir}, 0);
        check("dwell_ready", {31'd0, cmd_ready}, 0);
        next_tick();
        check("flip_width", width, 0);
        check("flip_dir", {31'd0, dir}, 1);
        check("flip_ready", {31'd0, cmd_ready}, 1);
        check("flip_busy", {31'd0, busy}, 1);
        exp_q.push_back(10); exp_q.push_back(20);
        run_queue("rev_ramp");
`else
        send(20, 1'b1);
        check("snap_width", width, 0);
        check("snap_dir", {31'd0, dir}, 1);
        check("snap_busy", {31'd0, busy}, 1);
        check("snap_ready", {31'd0, cmd_ready}, 1);
        exp_q.push_back(10); exp_q.push_back(20);
        run_queue("rev_ramp");
`endif
        check("rev_busy", {31'd0, busy}, 0);
        check("rev_dir", {31'd0, dir}, 1);

        // saturation at PERIOD+1
        send(5000, 1'b1);
        v = 20;
        while (v != PERIOD + 1) begin
            v = (PERIOD + 1 - v > STEP) ? v + STEP : PERIOD + 1;
            exp_q.push_back(BW'(v));
        end
        run_queue("sat_ramp");
        repeat (3) begin
            next_tick();
            check("sat_hold", width, PERIOD + 1);
        end
        check("sat_busy", {31'd0, busy}, 0);

        // asynchronous reset mid-ramp
        send(500, 1'b1);
        exp_q.push_back(991); exp_q.push_back(981);
        run_queue("down500");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_width", width, 0);
        check("async_rst_dir", {31'd0, dir}, 0);
        check("async_rst_busy", {31'd0, busy}, 0);
        check("async_rst_ready", {31'd0, cmd_ready}, 1);
        repeat (2) @(negedge clk);
        check("rst_held_width", width, 0);
        rst = 1'b0;
        send(25, 1'b0);
        exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(25);
        run_queue("post_rst_ramp");
        check("post_rst_busy", {31'd0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_duty_ramp.md
# motor_duty_ramp

Slew-rate limiter directly upstream of `pwm_generator` in the motor control path. Accepts duty/direction commands over a valid/ready handshake and drives the generator's `width` input, moving it toward the commanded duty by a bounded step once per update tick. Reversal requests decelerate to zero and dwell for one tick before the direction flips, so the H-bridge never sees an instantaneous reverse at speed.

## Interface
- `BAND_WIDTH`, 32: width of duty command and `width` output; must match `pwm_generator`.
- `PWM_PERIOD_CYCLE`, 1000: same value as the downstream generator; sets the duty clamp.
- `RAMP_STEP`, 10: maximum change of `width` per update tick; must be ≥1.
- `UPDATE_CYCLE`, 1000: clock cycles per update tick; must be ≥1.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted.
- `cmd_duty`  in  BAND_WIDTH  requested duty, unsigned, in `pwm_generator` width units.
- `cmd_dir`  in  1  requested direction (0 forward, 1 reverse).
- `width`  out  BAND_WIDTH  current duty to `pwm_generator`.
- `dir`  out  1  current direction to the H-bridge.
- `busy`  out  1  high while `width`/`dir` differ from the accepted target.

## Operation
- Accept on `cmd_valid && cmd_ready` at a rising edge. The target registers load on that edge. A newer command replaces an older target even if the ramp is unfinished.
- Clamp: `cmd_duty > PWM_PERIOD_CYCLE+1` is stored as `PWM_PERIOD_CYCLE+1`, which gives 100% duty downstream.
- Tick counter runs 0..UPDATE_CYCLE-1 and wraps. A tick is the cycle where the counter equals UPDATE_CYCLE-1. The counter free-runs and is never reset by commands.
- Step arithmetic uses unsigned differences only, with no overflow.
  - If target > width: width += min(RAMP_STEP, target−width).
  - If target < width: width −= min(RAMP_STEP, width−target).
- FSM states:
  - IDLE: width==target, dir==target_dir. busy=0, cmd_ready=1.
  - RAMP: same direction, stepping on each tick. busy=1, cmd_ready=1. Goes to IDLE when width reaches target.
  - DECEL: direction change requested, stepping toward 0 regardless of target duty. busy=1, cmd_ready=0. Goes to DWELL on the tick that makes width 0.
  - DWELL: width=0 for one full tick period. On the next tick, dir ← target_dir, then go to RAMP, or IDLE if target is 0. cmd_ready=0.
- Direction-change command while width==0 (IDLE or RAMP): enter DWELL directly.
- Command equal to the current state: no state change, busy stays 0.

## Timing
- Reset values: width=0, dir=0, busy=0, cmd_ready=1, tick counter=0, target=0, target_dir=0, state IDLE.
- Reset is asynchronous: all outputs take their reset values immediately, including mid-ramp. Release is synchronous to `clk`.
- `width`/`dir` change only on the edge ending a tick cycle. Latency from accept to first `width` change is 1..UPDATE_CYCLE cycles.
- `busy` rises on the edge after accept. It falls on the same edge where `width` reaches its final value.
- `cmd_ready` drops on the edge entering DECEL/DWELL and rises on the edge leaving DWELL.
- Accept coinciding with a tick: the step on that edge uses the old target. The new target applies from the next tick.

## Configuration
- `MOTOR_RAMP_REVERSE_GUARD_EN` defined: DECEL/DWELL behaviour as above.
- Not defined: DECEL and DWELL are removed and `cmd_ready` is constant 1.
  - A direction-change command forces width=0 and dir=cmd_dir on the edge after accept.
  - Width then ramps up from 0 on subsequent ticks.

## Test plan
1. Assert `rst` for 3 cycles → width=0, dir=0, busy=0, cmd_ready=1; deassert; no commands → all unchanged for 3000 cycles.
2. UPDATE_CYCLE=4, RAMP_STEP=10; accept duty=35, dir=0 → width 10, 20, 30, 35 on four consecutive ticks. busy falls with 35.
3. PWM_PERIOD_CYCLE=1000; accept duty=5000 → width saturates at 1001 and never exceeds it.
4. Guard enabled, width=30, dir=0; accept duty=20, dir=1 → cmd_ready=0; width 20, 10, 0; one dwell tick; dir=1; width 10, 20; cmd_ready=1.
5. Ramping toward 100 with width=30; accept duty=15, same dir → next ticks give 20, then 15. busy=0.
6. Assert `rst` asynchronously mid-ramp between clock edges → width and dir go to 0 before the next edge. After release, a new ramp starts from 0.
